fifo_rd_prefetch: RTL and testbench

Read-side controller for the dual-clock FIFO, in the `rclk` domain, paired with the dual-port FIFO memory. It produces the memory read address and the Gray-coded read pointer for the write domain, and compares that pointer with the synchronized write pointer to detect empty. Words read from the memory's combinational read port go into a 2-entry prefetch buffer, which presents them downstream on a valid/ready interface with full throughput.

---
 rtl/fifo_rd_prefetch.sv | 99 +++++++++
 tb/tb_fifo_rd_prefetch.sv | 250 +++++++++++++++++++++++++
 2 files changed

// File: rtl/fifo_rd_prefetch.sv
// Read-side controller of a dual-clock FIFO (rclk domain).
// Keeps the binary/Gray read pointer, detects empty from the synchronized
// write pointer, and moves words out of the memory's combinational read port
// into a 2-entry prefetch buffer. The buffer drains downstream at full rate.
//
// Handshake: a word transfers on a rising edge where dout_valid and dout_ready
// are both high. dout_valid never depends on dout_ready, and dout stays stable
// while dout_valid is high and dout_ready is low.
module fifo_rd_prefetch #(
  parameter int DATASIZE = 8,
  parameter int ADDRSIZE = 4
) (
  input  logic                rclk,
  input  logic                rrst,
  input  logic [ADDRSIZE:0]   rq2_wptr,
  input  logic [DATASIZE-1:0] rdata_mem,
  output logic [ADDRSIZE-1:0] raddr,
  output logic [ADDRSIZE:0]   rptr,
  output logic                rempty,
  output logic [DATASIZE-1:0] dout,
  output logic                dout_valid,
  input  logic                dout_ready
);

  logic [ADDRSIZE:0]   rbin;
  logic [ADDRSIZE:0]   rbin_next;
  logic [ADDRSIZE:0]   gray_next;
  logic [1:0]          cnt;
  logic [DATASIZE-1:0] head;
  logic [DATASIZE-1:0] tail;
  logic                pop;
  logic                fetch;

  // Pointer arithmetic, empty detection and transfer decisions.
  always_comb begin
    rbin_next = rbin + {{ADDRSIZE{1'b0}}, 1'b1};
    gray_next = rbin_next ^ (rbin_next >> 1);
    rempty    = (rptr == rq2_wptr);
    pop       = dout_valid & dout_ready;
    // A slot is free if fewer than two words are held, or the head leaves now.
    fetch     = !rempty & ((cnt < 2'd2) | pop);
  end

  assign raddr      = rbin[ADDRSIZE-1:0];
  assign dout       = head;
  assign dout_valid = (cnt != 2'd0);

  // Read pointer: advance by one on every fetch; Gray copy is registered.
  always_ff @(posedge rclk) begin
    if (rrst) begin
      rbin <= '0;
      rptr <= '0;
    end else if (fetch) begin
      rbin <= rbin_next;
      rptr <= gray_next;
    end
  end

  // Prefetch buffer: head is the oldest word, tail the next one.
  always_ff @(posedge rclk) begin
    if (rrst) begin
      cnt  <= 2'd0;
      head <= '0;
      tail <= '0;
    end else begin
      case (cnt)
        2'd0: begin
          if (fetch) begin
            head <= rdata_mem;
            cnt  <= 2'd1;
          end
        end
        2'd1: begin
          if (fetch && !pop) begin
            tail <= rdata_mem;
            cnt  <= 2'd2;
          end else if (fetch && pop) begin
            head <= rdata_mem;
          end else if (pop) begin
            cnt  <= 2'd0;
          end
        end
        2'd2: begin
          if (pop && fetch) begin
            head <= tail;
            tail <= rdata_mem;
          end else if (pop) begin
            head <= tail;
            cnt  <= 2'd1;
          end
        end
        default: begin
          // Occupancy 3 is unreachable; hold state.
        end
      endcase
    end
  end

endmodule

// File: tb/tb_fifo_rd_prefetch.sv
// Bench for fifo_rd_prefetch: a memory and write-side model drive the DUT,
// written words are queued as expected output, and a monitor compares every
// accepted word plus pointer/occupancy invariants derived from the read rules.
module tb_fifo_rd_prefetch;

  localparam int DW = 8;
  localparam int AW = 4;

  // ---------------- clock / reset ----------------
  logic          rclk = 1'b0;
  logic          rrst;
  logic [AW:0]   rq2_wptr;
  logic [DW-1:0] rdata_mem;
  logic [AW-1:0] raddr;
  logic [AW:0]   rptr;
  logic          rempty;
  logic [DW-1:0] dout;
  logic          dout_valid;
  logic          dout_ready;

  always #5 rclk = ~rclk;

  fifo_rd_prefetch #(.DATASIZE(DW), .ADDRSIZE(AW)) dut (
    .rclk(rclk), .rrst(rrst), .rq2_wptr(rq2_wptr), .rdata_mem(rdata_mem),
    .raddr(raddr), .rptr(rptr), .rempty(rempty), .dout(dout),
    .dout_valid(dout_valid), .dout_ready(dout_ready)
  );

  // ---------------- memory and write-side model ----------------
  logic [DW-1:0] mem [16];
  logic [AW:0]   wbin;
  assign rdata_mem = mem[raddr];

  // ---------------- scoreboard ----------------
  logic [DW-1:0] exp_q[$];
  logic [AW:0]   popped_cnt;
  int            checks = 0;
  int            failures = 0;

  function automatic logic [AW:0] gray(input logic [AW:0] b);
    return b ^ (b >> 1);
  endfunction

  function automatic logic [AW:0] gray2bin(input logic [AW:0] g);
    logic [AW:0] b;
    b[AW] = g[AW];
    for (int i = AW - 1; i >= 0; i--) b[i] = b[i+1] ^ g[i];
    return b;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge rclk);
    #1;
  endtask

  task automatic write_word(input logic [DW-1:0] d);
    mem[wbin[AW-1:0]] = d;
    wbin = wbin + 1'b1;
    rq2_wptr = gray(wbin);
    exp_q.push_back(d);
  endtask

  task automatic do_reset(input int cycles);
    rrst = 1'b1;
    wbin = '0;
    rq2_wptr = '0;
    exp_q.delete();
    popped_cnt = '0;
    for (int i = 0; i < cycles; i++) tick();
  endtask

  // ---------------- monitor ----------------
  logic          prev_ok = 1'b0;
  logic [AW:0]   prev_rb, prev_rptr, prev_buf;
  logic          prev_rempty, prev_pop, prev_valid, prev_ready;
  logic [DW-1:0] prev_dout;

  always @(negedge rclk) begin
    logic [AW:0]   rb;
    logic [AW:0]   buffered;
    logic [AW:0]   exp_rb;
    logic          exp_fetch;
    logic [DW-1:0] exp_word;
    if (rrst) begin
      prev_ok = 1'b0;
    end else begin
      rb       = gray2bin(rptr);
      buffered = rb - popped_cnt;
      check("occupancy_le2", 32'(buffered <= 2), 32'd1);
      check("valid_vs_occupancy", 32'(dout_valid), 32'(buffered != 0));
      check("raddr_vs_rptr", 32'(raddr), 32'(rb[AW-1:0]));
      check("rempty", 32'(rempty), 32'(rptr == rq2_wptr));
      if (prev_ok) begin
        exp_fetch = !prev_rempty && (prev_buf < 2 || prev_pop);
        exp_rb    = prev_rb + {{AW{1'b0}}, exp_fetch};
        check("rptr_step", 32'(rb), 32'(exp_rb));
        check("gray_one_bit", 32'($countones(rptr ^ prev_rptr) <= 1), 32'd1);
        if (!prev_rempty) check("fill_latency", 32'(dout_valid), 32'd1);
        if (prev_valid && !prev_ready) check("stall_hold", 32'(dout), 32'(prev_dout));
      end
      if (dout_valid && dout_ready) begin
        if (exp_q.size() == 0) begin
          check("pop_unexpected", 32'(dout), 32'hFFFF_FFFF);
        end else begin
          exp_word = exp_q.pop_front();
          check("pop_data", 32'(dout), 32'(exp_word));
        end
        popped_cnt = popped_cnt + 1'b1;
      end
      prev_ok     = 1'b1;
      prev_rb     = rb;
      prev_rptr   = rptr;
      prev_buf    = buffered;
      prev_rempty = rempty;
      prev_pop    = dout_valid && dout_ready;
      prev_valid  = dout_valid;
      prev_ready  = dout_ready;
      prev_dout   = dout;
    end
  end

  // ---------------- watchdog ----------------
  initial begin
    #500000;
    $display("FAIL watchdog timeout checks=%0d", checks);
    $fatal(1, "timeout");
  end

  // ---------------- stimulus ----------------
  initial begin
    for (int i = 0; i < 16; i++) mem[i] = '0;
    dout_ready = 1'b0;

    // Reset
    do_reset(2);
    check("rst_rempty", 32'(rempty), 32'd1);
    check("rst_valid", 32'(dout_valid), 32'd0);
    check("rst_rptr", 32'(rptr), 32'd0);
    check("rst_raddr", 32'(raddr), 32'd0);
    check("rst_dout", 32'(dout), 32'd0);
    rrst = 1'b0;

    // Single word
    write_word(8'hA5);
    tick();
    check("single_valid", 32'(dout_valid), 32'd1);
    check("single_dout", 32'(dout), 32'hA5);
    check("single_rptr", 32'(rptr), 32'd1);
    check("single_rempty", 32'(rempty), 32'd1);
    dout_ready = 1'b1;
    tick();
    dout_ready = 1'b0;
    check("single_drained", 32'(dout_valid), 32'd0);

    // Backpressure
    do_reset(2);
    rrst = 1'b0;
    for (int i = 1; i <= 5; i++) write_word(8'(i));
    check("bp_wptr", 32'(rq2_wptr), 32'h07);
    for (int i = 0; i < 4; i++) tick();
    check("bp_rptr_hold", 32'(rptr), 32'h03);
    check("bp_dout", 32'(dout), 32'h01);
    dout_ready = 1'b1;
    for (int i = 1; i <= 5; i++) begin
      check("bp_seq", 32'(dout), 32'(i));
      check("bp_seq_valid", 32'(dout_valid), 32'd1);
      tick();
    end
    check("bp_rptr_end", 32'(rptr), 32'h07);
    check("bp_empty_end", 32'(dout_valid), 32'd0);

    // Streaming, one word per cycle with no bubbles
    for (int i = 0; i < 20; i++) begin
      write_word(8'($urandom_range(0, 255)));
      tick();
      check("stream_valid", 32'(dout_valid), 32'd1);
    end
    tick();
    tick();
    check("stream_drained", 32'(dout_valid), 32'd0);

    // Pointer wrap: drain 30 words, then 4 more
    do_reset(1);
    rrst = 1'b0;
    dout_ready = 1'b1;
    for (int i = 0; i < 30; i++) begin
      write_word(8'($urandom_range(0, 255)));
      tick();
    end
    tick();
    tick();
    dout_ready = 1'b0;
    check("wrap_pre_raddr", 32'(raddr), 32'd14);
    check("wrap_pre_valid", 32'(dout_valid), 32'd0);
    for (int i = 0; i < 4; i++) write_word(8'h60 + 8'(i));
    tick();
    check("wrap_rptr_31", 32'(rptr), 32'h10);
    check("wrap_raddr_15", 32'(raddr), 32'd15);
    tick();
    check("wrap_rptr_0", 32'(rptr), 32'h00);
    check("wrap_raddr_0", 32'(raddr), 32'd0);
    dout_ready = 1'b1;
    tick();
    check("wrap_rptr_1", 32'(rptr), 32'h01);
    check("wrap_raddr_1", 32'(raddr), 32'd1);
    for (int i = 0; i < 4; i++) tick();
    check("wrap_drained", 32'(exp_q.size()), 32'd0);

    // Reset mid-operation with a full buffer and ready high
    dout_ready = 1'b0;
    for (int i = 0; i < 3; i++) write_word(8'h70 + 8'(i));
    tick();
    tick();
    check("midrst_full_valid", 32'(dout_valid), 32'd1);
    dout_ready = 1'b1;
    do_reset(1);
    check("midrst_valid", 32'(dout_valid), 32'd0);
    check("midrst_rptr", 32'(rptr), 32'd0);
    rrst = 1'b0;
    dout_ready = 1'b0;

    // Randomized traffic
    for (int i = 0; i < 2000; i++) begin
      dout_ready = ($urandom_range(0, 3) != 0);
      if (i % 200 < 20) dout_ready = 1'b0;
      if (exp_q.size() < 15 && $urandom_range(0, 2) != 0)
        write_word(8'($urandom_range(0, 255)));
      tick();
    end

    // Drain everything
    dout_ready = 1'b1;
    for (int i = 0; i < 100 && (exp_q.size() != 0 || dout_valid); i++) tick();
    check("final_queue_empty", 32'(exp_q.size()), 32'd0);
    check("final_valid", 32'(dout_valid), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
